// File: rtl/trap_ctrl.sv
// Commit-end trap controller: flushes the pipeline, emits trap CSR updates and a fetch redirect.
// Optional macro TRAP_VECTORED_EN: vectored interrupt entry when mtvec mode bits are 2'b01.
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic        i_except_valid,
    input  logic [3:0]  i_except_kind,
    input  logic [31:0] i_except_tval,
    input  logic        i_half,
    input  logic        i_trap_ebreak,
    input  logic [3:0]  i_int_cause,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_csr_we,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mcause,
    output logic [31:0] o_mtval,
    output logic        o_mret,
    output logic        o_busy
);

    localparam logic [3:0] K_NONE = 4'd0,  K_INTERRUPT = 4'd1, K_PC_MISALIGN = 4'd2,
                           K_MISPRED = 4'd3, K_FLUSH = 4'd4, K_LOAD_MISALIGN = 4'd5,
                           K_STORE_MISALIGN = 4'd6, K_TRAP = 4'd7, K_INVALID = 4'd8,
                           K_SYS = 4'd9, K_MRET = 4'd10;
    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_REDIRECT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_kind;
    logic [31:0]   r_pc;
    logic [31:0]   r_tval;
    logic          r_half;
    logic [31:0]   r_last_pc;
    logic          r_flush, r_redirect_valid, r_csr_we, r_mret;
    logic [31:0]   r_mepc, r_mcause, r_mtval;
`ifdef TRAP_VECTORED_EN
    logic [3:0]    r_int_cause;
`endif

    logic          w_accept;
    logic          w_known;
    logic [3:0]    w_kind_in;
    logic [31:0]   w_tval_in;
    logic          w_is_trap_in;
    logic [31:0]   w_mcause_in;
    logic [31:0]   w_mtval_in;
    logic [31:0]   w_trap_pc;
    logic [31:0]   w_target;

    assign w_accept  = (r_state == ST_IDLE) && i_valid && i_except_valid && (i_except_kind != K_NONE);
    // Kinds 11..15 are folded into INVALID_INSTR with a zero tval.
    assign w_known   = (i_except_kind <= K_MRET);
    assign w_kind_in = w_known ? i_except_kind : K_INVALID;
    assign w_tval_in = w_known ? i_except_tval : 32'h0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_is_trap_in = 1'b1;
        w_mcause_in  = 32'h0;
        w_mtval_in   = 32'h0;
        case (w_kind_in)
            K_INTERRUPT:      w_mcause_in = {1'b1, 27'b0, i_int_cause};
            K_PC_MISALIGN:    w_mtval_in  = w_tval_in;
            K_LOAD_MISALIGN:  begin w_mcause_in = 32'd4; w_mtval_in = w_tval_in; end
            K_STORE_MISALIGN: begin w_mcause_in = 32'd6; w_mtval_in = w_tval_in; end
            K_TRAP:           w_mcause_in = i_trap_ebreak ? 32'd3 : 32'd11;
            K_INVALID:        begin w_mcause_in = 32'd2; w_mtval_in = w_tval_in; end
            default:          w_is_trap_in = 1'b0;
        endcase
    end

    // mtvec and mepc are consumed live during the REDIRECT cycle.
    always_comb begin
        w_trap_pc = i_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
        if ((r_kind == K_INTERRUPT) && (i_mtvec[1:0] == 2'b01))
            w_trap_pc = (i_mtvec & ~32'h3) + {26'b0, r_int_cause, 2'b00};
`endif
        case (r_kind)
            K_MISPRED:       w_target = r_tval;
            K_FLUSH, K_SYS:  w_target = r_pc + (r_half ? 32'd2 : 32'd4);
            K_MRET:          w_target = i_mepc & ~32'h1;
            default:         w_target = w_trap_pc;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_kind           <= K_NONE;
            r_pc             <= 32'h0;
            r_tval           <= 32'h0;
            r_half           <= 1'b0;
            r_last_pc        <= RESET_PC;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_csr_we         <= 1'b0;
            r_mret           <= 1'b0;
            r_mepc           <= 32'h0;
            r_mcause         <= 32'h0;
            r_mtval          <= 32'h0;
`ifdef TRAP_VECTORED_EN
            r_int_cause      <= 4'h0;
`endif
        end else begin
            r_csr_we         <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_mret           <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_FLUSH;
                        r_cnt    <= CW'(FLUSH_CYCLES - 1);
                        r_kind   <= w_kind_in;
                        r_pc     <= i_pc;
                        r_tval   <= w_tval_in;
                        r_half   <= i_half;
                        r_flush  <= 1'b1;
                        r_csr_we <= w_is_trap_in;
                        if (w_is_trap_in) begin
                            r_mepc   <= i_pc;
                            r_mcause <= w_mcause_in;
                            r_mtval  <= w_mtval_in;
                        end
`ifdef TRAP_VECTORED_EN
                        r_int_cause <= i_int_cause;
`endif
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state          <= ST_REDIRECT;
                        r_flush          <= 1'b0;
                        r_redirect_valid <= 1'b1;
                        r_mret           <= (r_kind == K_MRET);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_last_pc <= w_target;
                end
            endcase
        end
    end

    assign o_flush          = r_flush;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = (r_state == ST_REDIRECT) ? w_target : r_last_pc;
    assign o_csr_we         = r_csr_we;
    assign o_mepc           = r_mepc;
    assign o_mcause         = r_mcause;
    assign o_mtval          = r_mtval;
    assign o_mret           = r_mret;
    assign o_busy           = (r_state != ST_IDLE);

endmodule
